// File: rtl/axis_mult_pkg.sv
// Shared types and default widths for the two-channel multiplier-feed arbiter.
package axis_mult_pkg;

   localparam int DEF_DATA_W        = 128;
   localparam int DEF_WEIGHT_W      = 8;
   localparam int DEF_MAX_PKT_BEATS = 256;
   localparam int PKT_CNT_W         = 16;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_GRANT0 = 2'd1,
      ST_GRANT1 = 2'd2
   } arb_state_t;

   typedef logic chan_id_t;

   localparam chan_id_t CH0 = 1'b0;
   localparam chan_id_t CH1 = 1'b1;

   function automatic arb_state_t grant_state(input chan_id_t ch);
      return ch ? ST_GRANT1 : ST_GRANT0;
   endfunction

endpackage

// File: rtl/axis_mult_rr_pick.sv
// Two-way round-robin pick: a lone valid wins, a tie goes to the channel
// that did not hold the previous grant.
module axis_mult_rr_pick
   import axis_mult_pkg::*;
(
   input  logic     i_valid0,
   input  logic     i_valid1,
   input  chan_id_t i_last_grant,
   output chan_id_t o_grant_id,
   output logic     o_grant_vld
);

   always_comb begin
      o_grant_vld = i_valid0 | i_valid1;
      if (i_valid0 && i_valid1) begin
         o_grant_id = ~i_last_grant;
      end else if (i_valid1) begin
         o_grant_id = CH1;
      end else begin
         o_grant_id = CH0;
      end
   end

endmodule

// File: rtl/axis_mult_arbiter.sv
// Packet-level arbiter feeding one multiplier from two AXI-stream sources.
// Optional per-packet beat watchdog is enabled by defining ARB_TIMEOUT_EN.
//
//   state     | meaning
//   ----------+---------------------------------------------------------
//   ST_IDLE   | no grant; all tready low, m_axis_tvalid low
//   ST_GRANT0 | channel 0 owns m_axis until its tlast transfers
//   ST_GRANT1 | channel 1 owns m_axis until its tlast transfers
module axis_mult_arbiter
   import axis_mult_pkg::*;
#(
   parameter int DATA_W        = DEF_DATA_W,
   parameter int WEIGHT_W      = DEF_WEIGHT_W,
   parameter int MAX_PKT_BEATS = DEF_MAX_PKT_BEATS
) (
   input  logic                 CLK,
   input  logic                 RST,
   input  logic [DATA_W-1:0]    s0_axis_tdata,
   input  logic                 s0_axis_tvalid,
   input  logic                 s0_axis_tlast,
   output logic                 s0_axis_tready,
   input  logic [DATA_W-1:0]    s1_axis_tdata,
   input  logic                 s1_axis_tvalid,
   input  logic                 s1_axis_tlast,
   output logic                 s1_axis_tready,
   input  logic [WEIGHT_W-1:0]  bWeight0,
   input  logic [WEIGHT_W-1:0]  bWeight1,
   output logic [DATA_W-1:0]    m_axis_tdata,
   output logic                 m_axis_tvalid,
   output logic                 m_axis_tlast,
   output logic                 m_axis_tuser,
   input  logic                 m_axis_tready,
   output logic [WEIGHT_W-1:0]  bWeight,
   output logic [PKT_CNT_W-1:0] pkt_cnt0,
   output logic [PKT_CNT_W-1:0] pkt_cnt1,
   output logic                 timeout_err
);

   localparam int BEAT_W = ($clog2(MAX_PKT_BEATS) + 1 > PKT_CNT_W) ?
                           ($clog2(MAX_PKT_BEATS) + 1) : PKT_CNT_W;

   arb_state_t           r_state;
   arb_state_t           w_state_nxt;
   chan_id_t             r_last_grant;
   chan_id_t             w_pick_id;
   chan_id_t             w_cur_id;
   logic                 w_pick_vld;
   logic                 w_cur_vld;
   logic                 w_oth_vld;
   logic                 w_src_last;
   logic                 w_at_limit;
   logic                 w_force_last;
   logic                 w_xfer;
   logic                 w_pkt_end;
   logic                 w_enter;
   logic [BEAT_W-1:0]    r_beat_cnt;
   logic [WEIGHT_W-1:0]  r_weight;
   logic [PKT_CNT_W-1:0] r_pkt_cnt0;
   logic [PKT_CNT_W-1:0] r_pkt_cnt1;

   axis_mult_rr_pick u_rr_pick (
      .i_valid0     (s0_axis_tvalid),
      .i_valid1     (s1_axis_tvalid),
      .i_last_grant (r_last_grant),
      .o_grant_id   (w_pick_id),
      .o_grant_vld  (w_pick_vld)
   );

`ifdef ARB_TIMEOUT_EN
   logic r_timeout_err;

   assign w_at_limit  = (r_beat_cnt == BEAT_W'(MAX_PKT_BEATS - 1));
   assign timeout_err = r_timeout_err;

   always_ff @(posedge CLK) begin
      if (RST) begin
         r_timeout_err <= 1'b0;
      end else if (w_pkt_end && w_force_last) begin
         r_timeout_err <= 1'b1;
      end
   end
`else
   assign w_at_limit  = 1'b0;
   assign timeout_err = 1'b0;
`endif

   always_comb begin
      w_state_nxt    = r_state;
      w_cur_id       = CH0;
      w_cur_vld      = 1'b0;
      w_oth_vld      = 1'b0;
      w_src_last     = 1'b0;
      m_axis_tdata   = '0;
      s0_axis_tready = 1'b0;
      s1_axis_tready = 1'b0;

      case (r_state)
         ST_GRANT0: begin
            w_cur_id       = CH0;
            w_cur_vld      = s0_axis_tvalid;
            w_oth_vld      = s1_axis_tvalid;
            w_src_last     = s0_axis_tlast;
            m_axis_tdata   = s0_axis_tdata;
            s0_axis_tready = m_axis_tready;
         end
         ST_GRANT1: begin
            w_cur_id       = CH1;
            w_cur_vld      = s1_axis_tvalid;
            w_oth_vld      = s0_axis_tvalid;
            w_src_last     = s1_axis_tlast;
            m_axis_tdata   = s1_axis_tdata;
            s1_axis_tready = m_axis_tready;
         end
         default: ;
      endcase

      m_axis_tvalid = w_cur_vld;
      m_axis_tuser  = w_cur_id;
      w_force_last  = (r_state != ST_IDLE) && w_at_limit && !w_src_last;
      m_axis_tlast  = w_src_last | w_force_last;
      w_xfer        = m_axis_tvalid & m_axis_tready;
      w_pkt_end     = w_xfer & m_axis_tlast;

      if (r_state == ST_IDLE) begin
         if (w_pick_vld) begin
            w_state_nxt = grant_state(w_pick_id);
         end
      end else if (w_pkt_end) begin
         if (w_oth_vld) begin
            w_state_nxt = grant_state(~w_cur_id);
         end else if (w_cur_vld) begin
            w_state_nxt = grant_state(w_cur_id);
         end else begin
            w_state_nxt = ST_IDLE;
         end
      end else if (!w_cur_vld && r_beat_cnt == '0) begin
         // Between packets with nothing pending: re-arbitrate so the other
         // channel cannot be starved by an idle owner.
         w_state_nxt = ST_IDLE;
      end

      w_enter = (w_state_nxt != ST_IDLE) && ((r_state == ST_IDLE) || w_pkt_end);
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         r_last_grant <= CH1;
         r_weight     <= '0;
         r_beat_cnt   <= '0;
         r_pkt_cnt0   <= '0;
         r_pkt_cnt1   <= '0;
      end else begin
         if (w_enter) begin
            r_last_grant <= (w_state_nxt == ST_GRANT1);
            r_weight     <= (w_state_nxt == ST_GRANT1) ? bWeight1 : bWeight0;
         end
         if (w_pkt_end) begin
            r_beat_cnt <= '0;
         end else if (w_xfer) begin
            r_beat_cnt <= r_beat_cnt + BEAT_W'(1);
         end
         if (w_pkt_end && !w_force_last) begin
            if (w_cur_id == CH1) begin
               r_pkt_cnt1 <= r_pkt_cnt1 + 16'd1;
            end else begin
               r_pkt_cnt0 <= r_pkt_cnt0 + 16'd1;
            end
         end
      end
   end

   assign bWeight  = r_weight;
   assign pkt_cnt0 = r_pkt_cnt0;
   assign pkt_cnt1 = r_pkt_cnt1;

endmodule

// File: tb/tb_axis_mult_arbiter.sv
// Scoreboard bench for axis_mult_arbiter; the watchdog case runs only when
// ARB_TIMEOUT_EN is defined (instance uses MAX_PKT_BEATS = 8).
module tb_axis_mult_arbiter;

   localparam int DW     = 128;
   localparam int WW     = 8;
   localparam int TB_MAX = 8;

   typedef struct {
      logic [DW-1:0] d;
      logic          l;
   } beat_t;

   logic          CLK = 1'b0;
   logic          RST = 1'b1;
   logic [DW-1:0] s_tdata [2];
   logic          s_tvalid [2];
   logic          s_tlast [2];
   logic          s0_tready, s1_tready;
   logic [WW-1:0] bWeight0, bWeight1, bWeight;
   logic [DW-1:0] m_tdata;
   logic          m_tvalid, m_tlast, m_tuser, m_tready;
   logic [15:0]   pkt_cnt0, pkt_cnt1;
   logic          timeout_err;

   int            n_chk = 0;
   int            n_bad = 0;
   int            n_xfer = 0;
   int            cyc = 0;
   logic          mon_en = 1'b1;
   logic [WW-1:0] exp_w0, exp_w1;
   beat_t         exp_q0 [$];
   beat_t         exp_q1 [$];
   int            log_cyc [$];
   logic          log_ch [$];
   logic          log_last [$];

   always #5 CLK = ~CLK;

   axis_mult_arbiter #(.DATA_W(DW), .WEIGHT_W(WW), .MAX_PKT_BEATS(TB_MAX)) dut (
      .CLK            (CLK),
      .RST            (RST),
      .s0_axis_tdata  (s_tdata[0]),
      .s0_axis_tvalid (s_tvalid[0]),
      .s0_axis_tlast  (s_tlast[0]),
      .s0_axis_tready (s0_tready),
      .s1_axis_tdata  (s_tdata[1]),
      .s1_axis_tvalid (s_tvalid[1]),
      .s1_axis_tlast  (s_tlast[1]),
      .s1_axis_tready (s1_tready),
      .bWeight0       (bWeight0),
      .bWeight1       (bWeight1),
      .m_axis_tdata   (m_tdata),
      .m_axis_tvalid  (m_tvalid),
      .m_axis_tlast   (m_tlast),
      .m_axis_tuser   (m_tuser),
      .m_axis_tready  (m_tready),
      .bWeight        (bWeight),
      .pkt_cnt0       (pkt_cnt0),
      .pkt_cnt1       (pkt_cnt1),
      .timeout_err    (timeout_err)
   );

   task automatic chk_eq(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h", tag, got, exp);
      end
   endtask

   function automatic logic rdy(input int ch);
      return (ch == 1) ? s1_tready : s0_tready;
   endfunction

   task automatic send_beat(input int ch, input logic [DW-1:0] d, input logic drv_last,
                            input logic exp_last);
      beat_t b;
      int    k;
      b.d = d;
      b.l = exp_last;
      s_tdata[ch]  = d;
      s_tlast[ch]  = drv_last;
      s_tvalid[ch] = 1'b1;
      if (ch == 1) exp_q1.push_back(b);
      else         exp_q0.push_back(b);
      k = 0;
      forever begin
         @(negedge CLK);
         if (rdy(ch) || k >= 200) break;
         k++;
      end
      chk_eq($sformatf("handshake_ch%0d", ch), rdy(ch), 1'b1);
      @(posedge CLK);
      #1;
      s_tvalid[ch] = 1'b0;
      s_tlast[ch]  = 1'b0;
   endtask

   task automatic send_pkt(input int ch, input int n, input int base);
      for (int i = 0; i < n; i++) begin
         send_beat(ch, DW'(base + i), (i == n - 1), (i == n - 1));
      end
   endtask

   task automatic wait_xfer(input int n, input string tag);
      int k;
      k = 0;
      while (n_xfer < n && k < 300) begin
         @(negedge CLK);
         k++;
      end
      chk_eq(tag, (n_xfer >= n), 1'b1);
   endtask

   task automatic reset_dut();
      RST = 1'b1;
      repeat (3) @(posedge CLK);
      #1;
      RST = 1'b0;
   endtask

   task automatic idle_cycles(input int n);
      repeat (n) @(posedge CLK);
      #1;
   endtask

   initial begin : cyc_cnt
      forever begin
         @(posedge CLK);
         cyc++;
      end
   end

   initial begin : monitor
      beat_t b;
      logic  ok;
      forever begin
         @(negedge CLK);
         if (mon_en && m_tvalid && m_tready) begin
            ok = 1'b0;
            if (m_tuser) begin
               ok = (exp_q1.size() > 0);
               if (ok) b = exp_q1.pop_front();
            end else begin
               ok = (exp_q0.size() > 0);
               if (ok) b = exp_q0.pop_front();
            end
            chk_eq("sb_has_exp", ok, 1'b1);
            if (ok) begin
               chk_eq("sb_data", m_tdata, b.d);
               chk_eq("sb_last", m_tlast, b.l);
               chk_eq("sb_weight", bWeight, m_tuser ? exp_w1 : exp_w0);
            end
            log_cyc.push_back(cyc);
            log_ch.push_back(m_tuser);
            log_last.push_back(m_tlast);
            n_xfer++;
         end
      end
   end

   initial begin : guard
      #500000;
      $display("FAIL global_timeout: got running want finished");
      $fatal(1);
   end

   initial begin : stim
      int n0;
      for (int c = 0; c < 2; c++) begin
         s_tdata[c]  = '0;
         s_tvalid[c] = 1'b0;
         s_tlast[c]  = 1'b0;
      end
      bWeight0 = 8'h40;
      bWeight1 = 8'h22;
      exp_w0   = 8'h40;
      exp_w1   = 8'h22;
      m_tready = 1'b1;

      // reset values
      RST = 1'b1;
      repeat (2) @(posedge CLK);
      @(negedge CLK);
      chk_eq("rst_m_tvalid", m_tvalid, 1'b0);
      chk_eq("rst_s0_tready", s0_tready, 1'b0);
      chk_eq("rst_s1_tready", s1_tready, 1'b0);
      chk_eq("rst_bweight", bWeight, 8'h00);
      chk_eq("rst_pkt_cnt0", pkt_cnt0, 16'h0);
      chk_eq("rst_pkt_cnt1", pkt_cnt1, 16'h0);
      chk_eq("rst_timeout_err", timeout_err, 1'b0);
      reset_dut();

      // single channel 0, weight 0x40, 4 beats
      fork
         send_pkt(0, 4, 'h100);
         begin
            @(negedge CLK);
            chk_eq("a_idle_tready", s0_tready, 1'b0);
            @(negedge CLK);
            chk_eq("a_grant_tready", s0_tready, 1'b1);
            chk_eq("a_tuser", m_tuser, 1'b0);
            chk_eq("a_bweight", bWeight, 8'h40);
         end
      join
      idle_cycles(2);
      chk_eq("a_pkt_cnt0", pkt_cnt0, 16'd1);
      chk_eq("a_q_empty", exp_q0.size(), 0);

      // both valid after reset: ch0 first, ch1 with no bubble
      reset_dut();
      log_cyc.delete();
      log_ch.delete();
      log_last.delete();
      fork
         send_pkt(0, 3, 'h200);
         send_pkt(1, 3, 'h300);
      join
      idle_cycles(2);
      chk_eq("b_nbeats", log_ch.size(), 6);
      chk_eq("b_first_ch", log_ch[0], 1'b0);
      chk_eq("b_ch0_last", log_last[2], 1'b1);
      chk_eq("b_switch_ch", log_ch[3], 1'b1);
      chk_eq("b_no_bubble", log_cyc[3] - log_cyc[2], 1);
      chk_eq("b_pkt_cnt0", pkt_cnt0, 16'd1);
      chk_eq("b_pkt_cnt1", pkt_cnt1, 16'd1);

      // back-pressure for 5 cycles mid-packet
      idle_cycles(3);
      n0 = n_xfer;
      fork
         send_pkt(0, 6, 'h400);
         begin
            wait_xfer(n0 + 2, "c_wait_two");
            @(posedge CLK);
            #1;
            m_tready = 1'b0;
            repeat (5) begin
               @(negedge CLK);
               chk_eq("c_hold_data", m_tdata, DW'('h402));
               chk_eq("c_hold_valid", m_tvalid, 1'b1);
               chk_eq("c_s0_tready", s0_tready, 1'b0);
            end
            @(posedge CLK);
            #1;
            m_tready = 1'b1;
         end
      join
      idle_cycles(2);
      chk_eq("c_beats", n_xfer - n0, 6);
      chk_eq("c_q_empty", exp_q0.size(), 0);
      chk_eq("c_pkt_cnt0", pkt_cnt0, 16'd2);

      // weight change mid-packet must not leak into the current packet
      n0 = n_xfer;
      fork
         send_pkt(0, 4, 'h500);
         begin
            wait_xfer(n0 + 2, "d_wait_two");
            @(posedge CLK);
            #1;
            bWeight0 = 8'h10;
            @(negedge CLK);
            chk_eq("d_weight_hold", bWeight, 8'h40);
         end
      join
      idle_cycles(3);
      exp_w0 = 8'h10;
      send_pkt(0, 2, 'h600);
      idle_cycles(2);
      chk_eq("d_weight_new", bWeight, 8'h10);
      chk_eq("d_pkt_cnt0", pkt_cnt0, 16'd4);

      // reset on beat 2 of 4
      send_beat(0, DW'('h700), 1'b0, 1'b0);
      send_beat(0, DW'('h701), 1'b0, 1'b0);
      s_tdata[0]  = DW'('h702);
      s_tlast[0]  = 1'b0;
      s_tvalid[0] = 1'b1;
      mon_en = 1'b0;
      RST = 1'b1;
      @(posedge CLK);
      @(negedge CLK);
      chk_eq("e_s0_tready", s0_tready, 1'b0);
      chk_eq("e_m_tvalid", m_tvalid, 1'b0);
      chk_eq("e_pkt_cnt0", pkt_cnt0, 16'd0);
      chk_eq("e_pkt_cnt1", pkt_cnt1, 16'd0);
      chk_eq("e_bweight", bWeight, 8'h00);
      RST = 1'b0;
      s_tvalid[0] = 1'b0;
      exp_q0.delete();
      exp_q1.delete();
      mon_en = 1'b1;
      idle_cycles(2);
      bWeight1 = 8'h33;
      exp_w1   = 8'h33;
      send_pkt(1, 2, 'h800);
      idle_cycles(2);
      chk_eq("e_after_pkt_cnt1", pkt_cnt1, 16'd1);
      chk_eq("e_after_pkt_cnt0", pkt_cnt0, 16'd0);

`ifdef ARB_TIMEOUT_EN
      // 12-beat packet against an 8-beat watchdog
      reset_dut();
      for (int i = 0; i < 12; i++) begin
         send_beat(1, DW'('h900 + i), (i == 11), (i == 7) || (i == 11));
         if (i == 7) begin
            chk_eq("t_err_set", timeout_err, 1'b1);
            chk_eq("t_cnt_after_force", pkt_cnt1, 16'd0);
         end
      end
      idle_cycles(2);
      chk_eq("t_err_sticky", timeout_err, 1'b1);
      chk_eq("t_pkt_cnt1", pkt_cnt1, 16'd1);
`else
      chk_eq("no_watchdog_err", timeout_err, 1'b0);
`endif

      chk_eq("final_q0_empty", exp_q0.size(), 0);
      chk_eq("final_q1_empty", exp_q1.size(), 0);
      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

endmodule
